// File: rtl/gps_frame_ctrl.sv
// rtl/gps_frame_ctrl.sv - sequences UART bytes into the "@@Ha" message buffer with header, checksum, terminator and timeout checks
//
// Ports:
//   CLOCK_10M   in   system clock
//   RESET       in   asynchronous reset, active-high
//   ENABLE      in   capture enable; low forces IDLE and discards any open frame
//   RDATA[7:0]  in   byte from UART_RX
//   VALID       in   UART_RX byte-valid level; one byte accepted per rising edge
//   WR_EN       out  buffer write strobe (one cycle)
//   WR_ADDR     out  buffer byte index
//   WR_DATA     out  buffer byte
//   BUSY        out  frame open (first '@' seen)
//   FRAME_DONE  out  one-cycle pulse: complete, valid frame stored
//   FRAME_ERR   out  one-cycle pulse: frame aborted
//   ERR_CODE    out  last error cause: 1 header, 2 checksum, 3 terminator, 4 timeout
//   FRAME_CNT   out  good-frame count, wraps
//   ERR_CNT     out  error count, saturates at 255

module gps_frame_ctrl #(
    parameter int         FRAME_LEN   = 154,
    parameter logic [7:0] HDR_ID0     = 8'h48,
    parameter logic [7:0] HDR_ID1     = 8'h61,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic        CLOCK_10M,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [7:0]  RDATA,
    input  logic        VALID,
    output logic        WR_EN,
    output logic [7:0]  WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        FRAME_ERR,
    output logic [2:0]  ERR_CODE,
    output logic [15:0] FRAME_CNT,
    output logic [7:0]  ERR_CNT
);

    localparam logic [7:0] SYNC_BYTE = 8'h40;
    localparam logic [7:0] CR_BYTE   = 8'h0D;
    localparam logic [7:0] LF_BYTE   = 8'h0A;

    localparam logic [7:0] LAST_BODY = 8'(FRAME_LEN - 4);
    localparam logic [7:0] ADDR_CK   = 8'(FRAME_LEN - 3);
    localparam logic [7:0] ADDR_CR   = 8'(FRAME_LEN - 2);
    localparam logic [7:0] ADDR_LF   = 8'(FRAME_LEN - 1);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    // gap holds the number of cycles elapsed since the last accept cycle, so
    // the error is registered on the edge where it would reach TIMEOUT_CYC-1.
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 2);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HUNT1 = 4'd1,
        S_HUNT2 = 4'd2,
        S_ID0   = 4'd3,
        S_ID1   = 4'd4,
        S_BODY  = 4'd5,
        S_CKSUM = 4'd6,
        S_CR    = 4'd7,
        S_LF    = 4'd8
    } state_t;

    state_t           state;
    logic             valid_q;
    logic [7:0]       idx;
    logic [7:0]       cksum;
    logic [GAP_W-1:0] gap;

    logic       accept;
    logic       in_frame;
    logic       err_hit;
    logic [2:0] err_code_c;

    assign accept   = VALID & ~valid_q;
    assign in_frame = (state != S_IDLE) && (state != S_HUNT1);

    // Error decode. An accepted byte always takes priority over the timeout.
    always_comb begin
        err_hit    = 1'b0;
        err_code_c = 3'd0;
        if (ENABLE) begin
            if (accept) begin
                case (state)
                    S_ID0: begin
                        if (RDATA != SYNC_BYTE && RDATA != HDR_ID0) begin
                            err_hit    = 1'b1;
                            err_code_c = 3'd1;
                        end
                    end
                    S_ID1: begin
                        if (RDATA != HDR_ID1) begin
                            err_hit    = 1'b1;
                            err_code_c = 3'd1;
                        end
                    end
                    S_CKSUM: begin
                        if (RDATA != cksum) begin
                            err_hit    = 1'b1;
                            err_code_c = 3'd2;
                        end
                    end
                    S_CR: begin
                        if (RDATA != CR_BYTE) begin
                            err_hit    = 1'b1;
                            err_code_c = 3'd3;
                        end
                    end
                    S_LF: begin
                        if (RDATA != LF_BYTE) begin
                            err_hit    = 1'b1;
                            err_code_c = 3'd3;
                        end
                    end
                    default: ;
                endcase
            end else if (in_frame && gap == GAP_LIMIT) begin
                err_hit    = 1'b1;
                err_code_c = 3'd4;
            end
        end
    end

    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            valid_q    <= 1'b0;
            idx        <= 8'd0;
            cksum      <= 8'd0;
            gap        <= '0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= 8'd0;
            WR_DATA    <= 8'd0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
            ERR_CODE   <= 3'd0;
            FRAME_CNT  <= 16'd0;
            ERR_CNT    <= 8'd0;
        end else begin
            valid_q    <= VALID;
            WR_EN      <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;

            if (in_frame) begin
                gap <= accept ? GAP_W'(1) : gap + 1'b1;
            end

            if (!ENABLE) begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
                gap   <= '0;
            end else if (err_hit) begin
                FRAME_ERR <= 1'b1;
                ERR_CODE  <= err_code_c;
                if (ERR_CNT != 8'hFF) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
                state <= S_HUNT1;
                BUSY  <= 1'b0;
                gap   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_HUNT1;
                    end
                    S_HUNT1: begin
                        if (accept && RDATA == SYNC_BYTE) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= 8'd0;
                            WR_DATA <= RDATA;
                            state   <= S_HUNT2;
                            BUSY    <= 1'b1;
                        end
                    end
                    S_HUNT2: begin
                        if (accept) begin
                            if (RDATA == SYNC_BYTE) begin
                                WR_EN   <= 1'b1;
                                WR_ADDR <= 8'd1;
                                WR_DATA <= RDATA;
                                cksum   <= 8'd0;
                                state   <= S_ID0;
                            end else begin
                                state <= S_HUNT1;
                                BUSY  <= 1'b0;
                                gap   <= '0;
                            end
                        end
                    end
                    S_ID0: begin
                        // Only '@' or HDR_ID0 reach here; other bytes are errors.
                        if (accept) begin
                            WR_EN   <= 1'b1;
                            WR_DATA <= RDATA;
                            if (RDATA == SYNC_BYTE) begin
                                WR_ADDR <= 8'd1;
                                cksum   <= 8'd0;
                            end else begin
                                WR_ADDR <= 8'd2;
                                cksum   <= RDATA;
                                state   <= S_ID1;
                            end
                        end
                    end
                    S_ID1: begin
                        if (accept) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= 8'd3;
                            WR_DATA <= RDATA;
                            cksum   <= cksum ^ RDATA;
                            idx     <= 8'd4;
                            // The shortest legal frame has no body bytes.
                            state   <= (FRAME_LEN == 7) ? S_CKSUM : S_BODY;
                        end
                    end
                    S_BODY: begin
                        if (accept) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= idx;
                            WR_DATA <= RDATA;
                            cksum   <= cksum ^ RDATA;
                            if (idx == LAST_BODY) begin
                                state <= S_CKSUM;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                    S_CKSUM: begin
                        if (accept) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= ADDR_CK;
                            WR_DATA <= RDATA;
                            state   <= S_CR;
                        end
                    end
                    S_CR: begin
                        if (accept) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= ADDR_CR;
                            WR_DATA <= RDATA;
                            state   <= S_LF;
                        end
                    end
                    S_LF: begin
                        if (accept) begin
                            WR_EN      <= 1'b1;
                            WR_ADDR    <= ADDR_LF;
                            WR_DATA    <= RDATA;
                            FRAME_DONE <= 1'b1;
                            FRAME_CNT  <= FRAME_CNT + 16'd1;
                            state      <= S_HUNT1;
                            BUSY       <= 1'b0;
                            gap        <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gps_frame_ctrl.sv
// tb/tb_gps_frame_ctrl.sv - scoreboard bench for gps_frame_ctrl with a byte-level reference model

module tb_gps_frame_ctrl;

    localparam int         FL  = 8;
    localparam int         TO  = 100;
    localparam logic [7:0] ID0 = 8'h48;
    localparam logic [7:0] ID1 = 8'h61;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic        valid = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  err_code;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    gps_frame_ctrl #(
        .FRAME_LEN  (FL),
        .HDR_ID0    (ID0),
        .HDR_ID1    (ID1),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLOCK_10M (clk),
        .RESET     (rst),
        .ENABLE    (enable),
        .RDATA     (rdata),
        .VALID     (valid),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .BUSY      (busy),
        .FRAME_DONE(frame_done),
        .FRAME_ERR (frame_err),
        .ERR_CODE  (err_code),
        .FRAME_CNT (frame_cnt),
        .ERR_CNT   (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // kind: 0 write, 1 frame done, 2 frame error
    typedef struct {
        int kind;
        int addr;
        int data;
        int v1;
        int v2;
        int at;
    } exp_t;

    exp_t q[$];

    // Reference model: pos = number of frame bytes currently held.
    int         pos = 0;
    int         m_fcnt = 0;
    int         m_ecnt = 0;
    logic [7:0] fr [0:255];
    int         last_acc = 0;
    logic [7:0] txq[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int kind, input int addr, input int data,
                            input int v1, input int v2, input int at);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        e.v1 = v1; e.v2 = v2; e.at = at;
        q.push_back(e);
    endtask

    task automatic wr(input int a, input logic [7:0] b);
        fr[a] = b;
        push_exp(0, a, int'(b), 0, 0, -1);
    endtask

    task automatic model_err(input int code, input int at);
        if (m_ecnt < 255) m_ecnt++;
        push_exp(2, 0, 0, code, m_ecnt, at);
        pos = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (pos == 0) begin
            if (b == 8'h40) begin wr(0, b); pos = 1; end
        end else if (pos == 1) begin
            if (b == 8'h40) begin wr(1, b); pos = 2; end
            else pos = 0;
        end else if (pos == 2) begin
            if (b == 8'h40) wr(1, b);
            else if (b == ID0) begin wr(2, b); pos = 3; end
            else model_err(1, -1);
        end else if (pos == 3) begin
            if (b == ID1) begin wr(3, b); pos = 4; end
            else model_err(1, -1);
        end else if (pos < FL - 3) begin
            wr(pos, b);
            pos++;
        end else if (pos == FL - 3) begin
            x = 8'd0;
            for (int i = 2; i <= FL - 4; i++) x = x ^ fr[i];
            if (b == x) begin wr(pos, b); pos++; end
            else model_err(2, -1);
        end else if (pos == FL - 2) begin
            if (b == 8'h0D) begin wr(pos, b); pos++; end
            else model_err(3, -1);
        end else begin
            if (b == 8'h0A) begin
                wr(pos, b);
                m_fcnt = (m_fcnt + 1) % 65536;
                push_exp(1, 0, 0, m_fcnt, 0, -1);
            end else begin
                model_err(3, -1);
            end
            pos = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rdata = b;
        valid = 1'b1;
        last_acc = cyc;
        model_byte(b);
        repeat (hold) tick();
        valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_txq(input int hold, input int gap, input bit rnd);
        while (txq.size() > 0) begin
            if (rnd) send_byte(txq.pop_front(), $urandom_range(1, 4), $urandom_range(1, 4));
            else send_byte(txq.pop_front(), hold, gap);
        end
    endtask

    // variant: 0 good, 1 bad checksum, 2 bad id, 3 bad terminator, 5 "@@@" good
    task automatic build_frame(input int variant);
        logic [7:0] x;
        logic [7:0] b;
        txq.push_back(8'h40);
        txq.push_back(8'h40);
        if (variant == 5) txq.push_back(8'h40);
        if (variant == 2) begin
            b = 8'($urandom);
            if (b == 8'h40 || b == ID0) b = 8'h00;
            txq.push_back(b);
        end else begin
            txq.push_back(ID0);
        end
        txq.push_back(ID1);
        x = ID0 ^ ID1;
        for (int i = 4; i <= FL - 4; i++) begin
            b = 8'($urandom);
            txq.push_back(b);
            x = x ^ b;
        end
        txq.push_back(variant == 1 ? (x ^ 8'h01) : x);
        txq.push_back(variant == 3 ? 8'h0E : 8'h0D);
        txq.push_back(8'h0A);
    endtask

    task automatic drop_enable();
        enable = 1'b0;
        pos = 0;
        tick();
        chk("busy_after_disable", int'(busy), 0);
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_err"}, int'(frame_err), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    exp_t mon_e;
    bit   mon_ok;

    task automatic take(input int kind, output exp_t e, output bit ok);
        if (q.size() == 0) begin
            checks++;
            failures++;
            ok = 1'b0;
            e.kind = -1; e.addr = 0; e.data = 0; e.v1 = 0; e.v2 = 0; e.at = -1;
            $display("FAIL unexpected_event actual_kind=%0d required=none (t=%0t)", kind, $time);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                take(0, mon_e, mon_ok);
                if (mon_ok) begin
                    chk("wr_addr", int'(wr_addr), mon_e.addr);
                    chk("wr_data", int'(wr_data), mon_e.data);
                end
            end
            if (frame_done) begin
                take(1, mon_e, mon_ok);
                if (mon_ok) chk("frame_cnt", int'(frame_cnt), mon_e.v1);
            end
            if (frame_err) begin
                take(2, mon_e, mon_ok);
                if (mon_ok) begin
                    chk("err_code", int'(err_code), mon_e.v1);
                    chk("err_cnt", int'(err_cnt), mon_e.v2);
                    if (mon_e.at >= 0) chk("timeout_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] fixed[8];

    initial begin
        fixed[0] = 8'h40; fixed[1] = 8'h40; fixed[2] = 8'h48; fixed[3] = 8'h61;
        fixed[4] = 8'h12; fixed[5] = 8'h3B; fixed[6] = 8'h0D; fixed[7] = 8'h0A;

        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();
        tick();

        // Known good frame, VALID held 4 cycles per byte.
        for (int i = 0; i < 8; i++) send_byte(fixed[i], 4, 1);
        tick();
        chk("first_frame_cnt", int'(frame_cnt), 1);
        chk("first_err_cnt", int'(err_cnt), 0);

        // Bad checksum, then a good frame.
        for (int i = 0; i < 8; i++) send_byte(i == 5 ? 8'h3A : fixed[i], 2, 1);
        tick();
        chk("cksum_err_code", int'(err_code), 2);
        chk("cksum_err_cnt", int'(err_cnt), 1);
        for (int i = 0; i < 8; i++) send_byte(fixed[i], 1, 1);
        tick();
        chk("after_err_frame_cnt", int'(frame_cnt), 2);

        // "@@@" header.
        send_byte(8'h40, 1, 1);
        for (int i = 0; i < 8; i++) send_byte(fixed[i], 1, 2);
        tick();
        chk("triple_at_frame_cnt", int'(frame_cnt), 3);

        // Randomized mix of frames and noise.
        for (int n = 0; n < 40; n++) begin
            int v;
            v = $urandom_range(0, 5);
            if (v == 4) begin
                int k;
                k = $urandom_range(1, 6);
                for (int j = 0; j < k; j++)
                    txq.push_back(($urandom_range(0, 1) == 1) ? 8'h40 : 8'($urandom));
            end else begin
                build_frame(v);
            end
            send_txq(0, 0, 1'b1);
        end
        drop_enable();
        chk("random_frame_cnt", int'(frame_cnt), m_fcnt);
        chk("random_err_cnt", int'(err_cnt), m_ecnt);

        // Enable dropped after the fourth byte of a frame.
        for (int i = 0; i < 4; i++) send_byte(fixed[i], 1, 1);
        chk("busy_mid_frame", int'(busy), 1);
        drop_enable();
        build_frame(0);
        send_txq(1, 1, 1'b0);
        tick();
        chk("reenable_frame_cnt", int'(frame_cnt), m_fcnt);

        // Inter-byte timeout.
        for (int i = 0; i < 5; i++) send_byte(fixed[i], 1, 1);
        model_err(4, last_acc + TO - 1);
        while (cyc < last_acc + TO - 2) tick();
        chk("busy_before_timeout", int'(busy), 1);
        while (cyc < last_acc + TO + 5) tick();
        chk("busy_after_timeout", int'(busy), 0);
        chk("timeout_err_code", int'(err_code), 4);

        // Bad-ID frames until the error counter saturates.
        for (int n = 0; n < 300; n++) begin
            send_byte(8'h40, 1, 1);
            send_byte(8'h40, 1, 1);
            send_byte(8'h00, 1, 1);
        end
        tick();
        chk("err_cnt_saturated", int'(err_cnt), 255);
        chk("sat_err_code", int'(err_code), 1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 3; i++) send_byte(fixed[i], 1, 1);
        tick();
        chk("queue_empty_before_reset", q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        q.delete();
        pos = 0;
        m_fcnt = 0;
        m_ecnt = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) send_byte(fixed[i], 1, 1);
        tick();
        chk("post_reset_frame_cnt", int'(frame_cnt), 1);

        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
